// File: rtl/axis_wrr_if.sv
// AXI-Stream bundle carrying N parallel lanes, each with its own valid, last and ready bits.
// The arbiter uses an N_CH-lane instance on its input side and a 1-lane instance on its output side.
interface axis_wrr_if #(
  parameter int N      = 1,
  parameter int DATA_W = 8,
  parameter int ID_W   = 4
);
  logic [N-1:0]        tvalid;
  logic [N*DATA_W-1:0] tdata;
  logic [N*ID_W-1:0]   tid;
  logic [N-1:0]        tlast;
  logic [N-1:0]        tready;

  modport master (output tvalid, tdata, tid, tlast, input tready);
  modport slave  (input tvalid, tdata, tid, tlast, output tready);
endinterface

// File: rtl/axis_wrr_arbiter.sv
// Packet-atomic weighted round-robin arbiter that merges N_CH AXI-Stream inputs into one output.
// Defining AXIS_WRR_STATS_EN adds per-channel counters of granted packets on pkt_cnt.
//
// state | meaning
// ARB   | pick a channel: keep the current one while it has credit, else rotate; outputs idle
// XFER  | pass the granted channel through combinationally until its tlast handshake
module axis_wrr_arbiter #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8,
  parameter int ID_W   = 4,
  parameter int WGT_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_CH*WGT_W-1:0]     weight,
  axis_wrr_if.slave                 s,
  axis_wrr_if.master                m,
  output logic [$clog2(N_CH)-1:0]   idx_channel,
  output logic [N_CH*CNT_W-1:0]     pkt_cnt
);
  localparam int IDX_W = $clog2(N_CH);

  typedef enum logic {ARB, XFER} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [WGT_W-1:0] credit_q, credit_d;
  logic [IDX_W-1:0] hit, cand;
  logic             hit_found;
  logic [WGT_W-1:0] hit_wgt;
  logic             beat_last;

  // Rotating search starting just after last_q; N_CH is a power of 2 so the add wraps naturally.
  always_comb begin
    hit_found = 1'b0;
    hit       = '0;
    cand      = '0;
    for (int i = 0; i < N_CH; i++) begin
      cand = last_q + IDX_W'(i + 1);
      if (!hit_found && s.tvalid[cand]) begin
        hit_found = 1'b1;
        hit       = cand;
      end
    end
    hit_wgt = weight[hit*WGT_W +: WGT_W];
  end

  assign beat_last = (state_q == XFER) && s.tvalid[grant_q] && m.tready[0] && s.tlast[grant_q];

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    credit_d = credit_q;
    s.tready = '0;
    m.tvalid = '0;
    m.tdata  = '0;
    m.tid    = '0;
    m.tlast  = '0;
    case (state_q)
      ARB: begin
        if (credit_q != '0 && s.tvalid[grant_q]) begin
          state_d = XFER;
        end else if (hit_found) begin
          grant_d  = hit;
          last_d   = hit;
          credit_d = (hit_wgt == '0) ? WGT_W'(1) : hit_wgt;
          state_d  = XFER;
        end else begin
          credit_d = '0;
        end
      end
      XFER: begin
        m.tvalid          = s.tvalid[grant_q];
        m.tdata           = s.tdata[grant_q*DATA_W +: DATA_W];
        m.tid             = s.tid[grant_q*ID_W +: ID_W];
        m.tlast           = s.tlast[grant_q];
        s.tready[grant_q] = m.tready[0];
        if (beat_last) begin
          credit_d = credit_q - WGT_W'(1);
          state_d  = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARB;
      grant_q     <= '0;
      last_q      <= IDX_W'(N_CH - 1);
      credit_q    <= '0;
      idx_channel <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      credit_q <= credit_d;
      if (state_q == ARB && state_d == XFER) idx_channel <= grant_d;
    end
  end

`ifdef AXIS_WRR_STATS_EN
  logic [N_CH*CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (beat_last && grant_q == IDX_W'(k))
          cnt_q[k*CNT_W +: CNT_W] <= cnt_q[k*CNT_W +: CNT_W] + CNT_W'(1);
      end
    end
  end

  assign pkt_cnt = cnt_q;
`else
  assign pkt_cnt = '0;
`endif
endmodule

// File: tb/tb_axis_wrr_arbiter.sv
// Self-checking bench for axis_wrr_arbiter: table-driven packet scenarios plus hand-written
// mid-packet arrival and mid-packet reset sequences, checked through a per-channel scoreboard.
module tb_axis_wrr_arbiter;
  localparam int N_CH   = 4;
  localparam int DATA_W = 8;
  localparam int ID_W   = 4;
  localparam int WGT_W  = 4;
  localparam int CNT_W  = 4;
  localparam int DEPTH  = 64;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic [N_CH*WGT_W-1:0]   weight = '0;
  logic [1:0]              idx_channel;
  logic [N_CH*CNT_W-1:0]   pkt_cnt;

  axis_wrr_if #(.N(N_CH), .DATA_W(DATA_W), .ID_W(ID_W)) s_if ();
  axis_wrr_if #(.N(1),    .DATA_W(DATA_W), .ID_W(ID_W)) m_if ();

  axis_wrr_arbiter #(
    .N_CH(N_CH), .DATA_W(DATA_W), .ID_W(ID_W), .WGT_W(WGT_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .weight(weight),
    .s(s_if),
    .m(m_if),
    .idx_channel(idx_channel),
    .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int scen;
    int ch;
    int len;
    int exp_ch;
  } vec_t;

  vec_t        tbl[24];
  logic [12:0] src_mem[N_CH][DEPTH];
  logic [12:0] exp_mem[N_CH][DEPTH];
  int          src_hd[N_CH];
  int          src_tl[N_CH];
  int          exp_rd[N_CH];
  int          exp_wr[N_CH];
  int          model_cnt[N_CH];
  int          exp_grant[$];
  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  int          last_tl = -1;
  int          gap_exp = 0;
  int          cur_ch = 0;
  int          seq = 0;
  bit          in_pkt = 1'b0;
  bit          rand_rdy = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic flush();
    for (int k = 0; k < N_CH; k++) begin
      src_hd[k] = 0; src_tl[k] = 0; exp_rd[k] = 0; exp_wr[k] = 0; model_cnt[k] = 0;
    end
    exp_grant.delete();
    in_pkt  = 1'b0;
    last_tl = -1;
  endtask

  task automatic push_pkt(input int ch, input int len);
    logic [12:0] b;
    for (int i = 0; i < len; i++) begin
      b = {(i == len - 1), 4'(seq), 8'(seq * 7 + ch)};
      seq++;
      src_mem[ch][src_tl[ch]] = b;
      exp_mem[ch][exp_wr[ch]] = b;
      src_tl[ch]++;
      exp_wr[ch]++;
    end
  endtask

  task automatic drive();
    logic [N_CH-1:0]        v, l;
    logic [N_CH*DATA_W-1:0] d;
    logic [N_CH*ID_W-1:0]   id;
    logic [12:0]            b;
    v = '0; l = '0; d = '0; id = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (src_hd[k] < src_tl[k]) begin
        b = src_mem[k][src_hd[k]];
        v[k] = 1'b1;
        l[k] = b[12];
        id[k*ID_W +: ID_W]     = b[11:8];
        d[k*DATA_W +: DATA_W]  = b[7:0];
      end
    end
    s_if.tvalid = v;
    s_if.tlast  = l;
    s_if.tid    = id;
    s_if.tdata  = d;
    m_if.tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  // Sample at negedge the handshakes the next posedge will take, then drive after that posedge.
  task automatic step();
    logic [12:0] b;
    @(negedge clk);
    cycle++;
    for (int k = 0; k < N_CH; k++)
      if (s_if.tvalid[k] && s_if.tready[k]) src_hd[k]++;
    if (m_if.tvalid[0] && m_if.tready[0]) begin
      if (!in_pkt) begin
        if (exp_grant.size() == 0) begin
          chk("unexpected_packet", 1, 0);
        end else begin
          cur_ch = exp_grant.pop_front();
          in_pkt = 1'b1;
          chk("grant_idx", int'(idx_channel), cur_ch);
        end
      end
      if (in_pkt) begin
        if (exp_rd[cur_ch] >= exp_wr[cur_ch]) begin
          chk("extra_beat", 1, 0);
        end else begin
          b = exp_mem[cur_ch][exp_rd[cur_ch]];
          exp_rd[cur_ch]++;
          chk("beat", int'({m_if.tlast[0], m_if.tid, m_if.tdata}), int'(b));
        end
        if (m_if.tlast[0]) begin
          in_pkt = 1'b0;
          model_cnt[cur_ch]++;
          if (gap_exp != 0 && last_tl >= 0) chk("pkt_cycles", cycle - last_tl, gap_exp);
          last_tl = cycle;
        end
      end
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flush();
    drive();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_m_tvalid", int'(m_if.tvalid), 0);
    chk("rst_s_tready", int'(s_if.tready), 0);
    chk("rst_m_tdata", int'({m_if.tlast, m_if.tid, m_if.tdata}), 0);
    chk("rst_idx", int'(idx_channel), 0);
    chk("rst_pkt_cnt", int'(pkt_cnt), 0);
    reset = 1'b0;
  endtask

  task automatic run_until_done(input int limit);
    int n = 0;
    while ((exp_grant.size() != 0 || in_pkt) && n < limit) begin
      step();
      n++;
    end
    if (n >= limit) begin
      errors++;
      $display("FAIL timeout: got %0d cycles expected completion, %0d packets pending", n, exp_grant.size());
    end
  endtask

  task automatic step_until(input int ch, input int cnt, input int limit);
    int n = 0;
    while (src_hd[ch] < cnt && n < limit) begin
      step();
      n++;
    end
    if (n >= limit) begin
      errors++;
      $display("FAIL wait_ch%0d: got %0d beats expected %0d", ch, src_hd[ch], cnt);
    end
  endtask

  task automatic check_cnt();
    int e;
    for (int k = 0; k < N_CH; k++) begin
`ifdef AXIS_WRR_STATS_EN
      e = model_cnt[k] % (1 << CNT_W);
`else
      e = 0;
`endif
      chk($sformatf("pkt_cnt_ch%0d", k), int'(pkt_cnt[k*CNT_W +: CNT_W]), e);
    end
  endtask

  int                    ord_b[12] = '{0, 0, 0, 1, 2, 3, 0, 0, 0, 1, 2, 3};
  logic [N_CH*WGT_W-1:0] wgt_s[3]  = '{16'h1111, 16'h1113, 16'h0000};
  int                    gap_s[3]  = '{3, 2, 4};

  initial begin
    s_if.tvalid = '0; s_if.tdata = '0; s_if.tid = '0; s_if.tlast = '0;
    m_if.tready = 1'b1;
    for (int i = 0; i < 8; i++)  tbl[i]      = '{0, i % 4, 2, i % 4};
    for (int i = 0; i < 12; i++) tbl[8 + i]  = '{1, ord_b[i], 1, ord_b[i]};
    for (int i = 0; i < 4; i++)  tbl[20 + i] = '{2, 2, 3, 2};

    // Round-robin with weight 1, weighted 3:1:1:1, and weight-0 single channel.
    for (int s = 0; s < 3; s++) begin
      weight   = wgt_s[s];
      rand_rdy = 1'b0;
      do_reset();
      gap_exp = gap_s[s];
      for (int i = 0; i < 24; i++) begin
        if (tbl[i].scen == s) begin
          push_pkt(tbl[i].ch, tbl[i].len);
          exp_grant.push_back(tbl[i].exp_ch);
        end
      end
      drive();
      run_until_done(500);
      check_cnt();
    end

    // ch0 arrives while ch1 is mid-packet, random output backpressure.
    weight   = 16'h1111;
    rand_rdy = 1'b1;
    do_reset();
    gap_exp = 0;
    push_pkt(1, 5);
    exp_grant.push_back(1);
    drive();
    step_until(1, 2, 200);
    push_pkt(0, 3);
    exp_grant.push_back(0);
    run_until_done(500);

    // Reset lands while ch3 presents beat 3 of 6.
    rand_rdy = 1'b0;
    do_reset();
    push_pkt(3, 6);
    exp_grant.push_back(3);
    drive();
    step_until(3, 2, 100);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_m_tvalid", int'(m_if.tvalid), 0);
    chk("midrst_s_tready", int'(s_if.tready), 0);
    chk("midrst_idx", int'(idx_channel), 0);
    flush();
    drive();
    @(posedge clk);
    #1;
    reset = 1'b0;
    push_pkt(2, 2);
    push_pkt(1, 2);
    exp_grant.push_back(1);
    exp_grant.push_back(2);
    drive();
    run_until_done(200);

    // 17 packets on ch3 wrap a 4-bit counter back to 1.
    do_reset();
    gap_exp = 2;
    for (int i = 0; i < 17; i++) begin
      push_pkt(3, 1);
      exp_grant.push_back(3);
    end
    drive();
    run_until_done(500);
    check_cnt();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
